// File: rtl/seven_segment_mux.sv
// Time-multiplexed N-digit hex seven-segment driver with dead-time between
// digit slots, per-digit decimal points and optional leading-zero blanking.
module seven_segment_mux #(
  parameter int unsigned NUM_DIGITS       = 4,
  parameter int unsigned CLKS_PER_DIGIT   = 25000,
  parameter int unsigned DEAD_CLKS        = 250,
  parameter bit          SEG_ACTIVE_LOW   = 1'b1,
  parameter bit          DIGIT_ACTIVE_LOW = 1'b1
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst,
  input  logic                    i_Load,
  input  logic [4*NUM_DIGITS-1:0] i_Value,
  input  logic [NUM_DIGITS-1:0]   i_Dp,
  input  logic                    i_Blank_Lz,
  output logic [6:0]              o_Segments,
  output logic                    o_Dp,
  output logic [NUM_DIGITS-1:0]   o_Digit_En,
  output logic                    o_Frame_Tick
);

  localparam int unsigned CntW = (CLKS_PER_DIGIT > 1) ? $clog2(CLKS_PER_DIGIT) : 1;
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CntW-1:0]       CntLast = CntW'(CLKS_PER_DIGIT - 1);
  localparam logic [IdxW-1:0]       IdxLast = IdxW'(NUM_DIGITS - 1);
  // Physical "off" levels for the output pins
  localparam logic [6:0]            SegOff  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic                  DpOff   = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] DigOff  = DIGIT_ACTIVE_LOW ? '1 : '0;

  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic                    wrap_q, wrap_d;
  logic [4*NUM_DIGITS-1:0] shadow_q;
  logic [NUM_DIGITS-1:0]   shadow_dp_q;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   dig_en_q, dig_en_d;
  logic                    tick_q;

  logic                    slot_last;
  logic                    in_dead;
  logic [3:0]              nib;
  logic                    dp_bit;
  logic                    blank;
  logic                    upper_zero;
  logic [6:0]              lit_seg;
  logic [NUM_DIGITS-1:0]   en_oh;

  // Hex nibble to segments A..G, lit = 1
  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h7E;
      4'h1: s = 7'h30;
      4'h2: s = 7'h6D;
      4'h3: s = 7'h79;
      4'h4: s = 7'h33;
      4'h5: s = 7'h5B;
      4'h6: s = 7'h5F;
      4'h7: s = 7'h70;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h7B;
      4'hA: s = 7'h77;
      4'hB: s = 7'h1F;
      4'hC: s = 7'h4E;
      4'hD: s = 7'h3D;
      4'hE: s = 7'h4F;
      4'hF: s = 7'h47;
    endcase
    return s;
  endfunction

  // Slot counter and digit index sequencing
  always_comb begin
    slot_last = (cnt_q == CntLast);
    in_dead   = (32'(cnt_q) < DEAD_CLKS);
    cnt_d     = slot_last ? '0 : cnt_q + 1'b1;
    idx_d     = idx_q;
    if (slot_last) begin
      idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
    end
    wrap_d = slot_last && (idx_q == IdxLast);
  end

  // Select the current nibble; blank it if it and every higher nibble are zero
  always_comb begin
    nib        = 4'h0;
    dp_bit     = 1'b0;
    blank      = 1'b0;
    upper_zero = 1'b1;
    for (int j = NUM_DIGITS - 1; j >= 0; j--) begin
      upper_zero = upper_zero && (shadow_q[4*j +: 4] == 4'h0);
      if (IdxW'(j) == idx_q) begin
        nib    = shadow_q[4*j +: 4];
        dp_bit = shadow_dp_q[j];
        blank  = i_Blank_Lz && (j != 0) && upper_zero;
      end
    end
  end

  // Next output values, converted to pin polarity
  always_comb begin
    seg_d    = SegOff;
    dp_d     = DpOff;
    dig_en_d = DigOff;
    lit_seg  = blank ? 7'h00 : hex_to_seg(nib);
    en_oh    = '0;
    en_oh[idx_q] = 1'b1;
    if (!in_dead) begin
      seg_d    = SEG_ACTIVE_LOW ? ~lit_seg : lit_seg;
      dp_d     = SEG_ACTIVE_LOW ? ~dp_bit : dp_bit;
      dig_en_d = DIGIT_ACTIVE_LOW ? ~en_oh : en_oh;
    end
  end

  // Scan state, shadow registers and registered outputs
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      wrap_q      <= 1'b0;
      shadow_q    <= '0;
      shadow_dp_q <= '0;
      seg_q       <= SegOff;
      dp_q        <= DpOff;
      dig_en_q    <= DigOff;
      tick_q      <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      wrap_q   <= wrap_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      dig_en_q <= dig_en_d;
      // wrap_q marks that the previous edge closed the last digit slot
      tick_q   <= wrap_q;
      if (i_Load) begin
        shadow_q    <= i_Value;
        shadow_dp_q <= i_Dp;
      end
    end
  end

  assign o_Segments   = seg_q;
  assign o_Dp         = dp_q;
  assign o_Digit_En   = dig_en_q;
  assign o_Frame_Tick = tick_q;

endmodule
